lsu_mem_master: RTL and testbench
=================================

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have parameter SPLIT_MISALIGNED, default 1: 1 = split misaligned half/word accesses into byte beats; 0 = reject them with an error.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state is updated on the posedge.
REQ-003 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port i_clk_enable, input, 1: global advance enable, shared with the data memory.
REQ-005 SHALL have port i_req_valid, input, 1: pipeline request present.
REQ-006 SHALL have port o_req_ready, output, 1: request accepted this cycle.
REQ-007 SHALL have port i_req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port i_req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port i_req_unsigned, input, 1: load zero-extend (1) or sign-extend (0).
REQ-010 SHALL have port i_req_addr, input, 32: byte address.
REQ-011 SHALL have port i_req_wdata, input, 32: store data, LSB-aligned.
REQ-012 SHALL have port o_busy, output, 1: pipeline stall, high whenever not IDLE.
REQ-013 SHALL have port o_rsp_valid, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port o_rsp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-015 SHALL have port o_rsp_err, output, 1: illegal size, or misaligned access with SPLIT_MISALIGNED=0.
REQ-016 SHALL have port o_mem_write, output, 1: write strobe to the data memory.
REQ-017 SHALL have port o_mem_addr, output, 32: memory byte address.
REQ-018 SHALL have port o_mem_data, output, 32: memory write data.
REQ-019 SHALL have port o_store_byte, output, 1: memory byte-store select.
REQ-020 SHALL have port o_store_half, output, 1: memory half-store select.
REQ-021 SHALL have port i_mem_data, input, 32: combinational memory read data, where [7:0] = byte at addr, [15:8] = addr+1, [23:16] = addr+2 and [31:24] = addr+3.

Function
REQ-022 SHALL implement FSM states IDLE, XFER and RESP; no transition SHALL occur in any cycle where i_clk_enable=0.
REQ-023 SHALL drive o_req_ready=1 only in IDLE; a request is accepted when i_req_valid and o_req_ready are both high on an enabled edge, and all request fields are latched on that edge.
REQ-024 SHALL go IDLE->XFER on accept, unless the request is an error, in which case it SHALL go IDLE->RESP with no memory access.
REQ-025 SHALL treat a request as aligned when byte size, or half with addr[0]=0, or word with addr[1:0]=00; an aligned request SHALL take exactly 1 XFER beat.
REQ-026 SHALL give a misaligned request with SPLIT_MISALIGNED=1 N beats (half: N=2, word: N=4); beat k SHALL use o_mem_addr = addr+k, byte mode, and data byte k.
REQ-027 SHALL, in XFER, drive o_mem_addr from the latched address plus beat count, and o_mem_data from the latched wdata (byte k in [7:0] when splitting).
REQ-028 SHALL assert o_mem_write only in XFER for stores; o_store_byte/o_store_half SHALL encode size (byte: 1/0, half: 0/1, word: 0/0) and SHALL be 1/0 on split beats.
REQ-029 SHALL drive o_mem_write, o_store_byte and o_store_half to 0 outside XFER.
REQ-030 SHALL, for loads, capture i_mem_data on each enabled XFER edge into an assembly register (aligned: whole word; split beat k: [7:0] into byte lane k).
REQ-031 SHALL count beats with a 2-bit counter that advances only on enabled edges and transitions to RESP after beat N-1.
REQ-032 SHALL, in RESP, assert o_rsp_valid for exactly one enabled cycle, then return to IDLE; o_rsp_rdata and o_rsp_err SHALL be registered and valid with o_rsp_valid.
REQ-033 SHALL extend load data: byte uses bit 7, half uses bit 15; unsigned zero-fills; a word is passed unchanged.
REQ-034 SHALL drive o_busy = (state != IDLE); it is purely decoded from the state register.
REQ-035 SHALL give a latency of accept edge -> o_rsp_valid high of (N+1) enabled cycles, and 1 enabled cycle for errors.
REQ-036 SHALL wrap address arithmetic mod 2^32 (e.g. word at 0xFFFFFFFE -> beats at FFFFFFFE, FFFFFFFF, 00000000, 00000001).
REQ-037 SHALL ignore i_req_valid while not IDLE; back-to-back requests SHALL be separated by at least the RESP cycle.

Reset
REQ-038 SHALL, when i_rst_n=0, asynchronously force state IDLE, beat count 0, and o_rsp_valid, o_rsp_err, o_mem_write, o_store_byte and o_store_half to 0, and o_rsp_rdata and the assembly register to 0.
REQ-039 SHALL abort an in-flight split access on reset with no further beats; already-written bytes remain in memory.
REQ-040 SHALL drive o_req_ready=1 on the first cycle after reset release.

Verification
REQ-041 SHALL cover: store word 0xDEADBEEF @0x100, then load word @0x100 -> 1 XFER beat, o_mem_write pulses once with store 0/0, o_rsp_rdata=0xDEADBEEF 2 cycles after accept.
REQ-042 SHALL cover: memory bytes 0x80,0x7F at 0x200..0x201; lb @0x200 -> 0xFFFFFF80; lbu -> 0x00000080; lh -> 0x00007F80.
REQ-043 SHALL cover: with SPLIT_MISALIGNED=1, sw 0x11223344 @0x103 -> 4 byte beats at 0x103..0x106 with data 44,33,22,11; lw @0x103 -> 0x11223344, rsp after 5 cycles.
REQ-044 SHALL cover: size=11, or SPLIT_MISALIGNED=0 with lh @0x201 -> no o_mem_write, o_rsp_err=1, rdata 0, 1 cycle after accept.
REQ-045 SHALL cover: i_clk_enable held low for 3 cycles mid-split -> beat address and state frozen, no extra writes, correct final data.
REQ-046 SHALL cover: i_rst_n asserted during beat 2 of a split store -> outputs 0 immediately, IDLE, ready high after release, and beats 3..N absent.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master -- load/store unit master toward a byte-addressed data memory.
//
// Takes one load/store request at a time from the pipeline, runs it against a
// single-port data memory (combinational read, clocked write with byte/half
// select) and returns one response pulse. A misaligned half or word can either
// be split into byte beats (SPLIT_MISALIGNED=1) or rejected with an error
// (SPLIT_MISALIGNED=0). Every state update is gated by i_clk_enable, which the
// data memory also uses.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_clk_enable        global advance enable
//   i_req_*/o_req_ready request handshake (we, size, unsigned, addr, wdata)
//   o_busy              pipeline stall, high whenever not IDLE
//   o_rsp_valid/rdata/err  one-cycle completion with extended load data
//   o_mem_*, o_store_*  memory address, write data and write strobes
//   i_mem_data          memory read data, [7:0] = byte at o_mem_addr

// One byte lane of the load assembly register. The lane takes the whole-word
// byte on an aligned beat, or the beat byte (always read data [7:0]) when the
// current split beat targets this lane. o_next is the value the lane will hold
// after this edge, so the response can be built in the same edge as the last
// capture.
module lsu_asm_lane (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic       i_cap,
  input  logic       i_split,
  input  logic [7:0] i_word_byte,
  input  logic [7:0] i_beat_byte,
  output logic [7:0] o_next
);
  logic [7:0] r_q;

  always_comb begin
    o_next = r_q;
    if (i_clr)      o_next = '0;
    else if (i_cap) o_next = i_split ? i_beat_byte : i_word_byte;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_q <= '0;
    else if (i_en) r_q <= o_next;
  end
endmodule

module lsu_mem_master #(
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clk_enable,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_busy,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  output logic        o_store_byte,
  output logic        o_store_half,
  input  logic [31:0] i_mem_data
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic        split;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic [1:0] r_state;
  logic [1:0] r_beat;
  req_t       r_req;

  logic       w_idle, w_xfer, w_accept;
  logic       w_misal, w_req_err, w_last, w_ld;
  logic [7:0] w_beat_byte;
  logic [31:0] w_asm, w_ext;
  logic [NUM_LANES-1:0][LANE_W-1:0] w_lane_next;

  assign w_idle   = (r_state == S_IDLE);
  assign w_xfer   = (r_state == S_XFER);
  assign w_accept = i_clk_enable && i_req_valid && w_idle;

  // Request classification from the live request fields.
  always_comb begin
    w_misal = ((i_req_size == SZ_HALF) && i_req_addr[0]) ||
              ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));
    w_req_err = (i_req_size == SZ_BAD) || (w_misal && (SPLIT_MISALIGNED == 0));
  end

  // Final beat: aligned requests take one beat, split half two, split word four.
  always_comb begin
    if (!r_req.split)               w_last = 1'b1;
    else if (r_req.size == SZ_HALF) w_last = (r_beat == 2'd1);
    else                            w_last = (r_beat == 2'd3);
  end

  assign o_req_ready = w_idle;
  assign o_busy      = !w_idle;
  assign o_rsp_valid = (r_state == S_RESP);

  // Memory side. Address wraps naturally in 32 bits.
  assign o_mem_addr   = r_req.addr + {30'd0, r_beat};
  assign w_beat_byte  = r_req.wdata[{r_beat, 3'b000} +: 8];
  assign o_mem_data   = r_req.split ? {24'd0, w_beat_byte} : r_req.wdata;
  assign o_mem_write  = w_xfer && r_req.we;
  assign o_store_byte = w_xfer && (r_req.split || (r_req.size == SZ_BYTE));
  assign o_store_half = w_xfer && !r_req.split && (r_req.size == SZ_HALF);

  // Load assembly register, one lane per byte.
  assign w_ld = w_xfer && !r_req.we;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_asm_lane u_lane (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_en        (i_clk_enable),
      .i_clr       (w_accept),
      .i_cap       (w_ld && (!r_req.split || (r_beat == 2'(g)))),
      .i_split     (r_req.split),
      .i_word_byte (i_mem_data[g*LANE_W +: LANE_W]),
      .i_beat_byte (i_mem_data[LANE_W-1:0]),
      .o_next      (w_lane_next[g])
    );
  end

  assign w_asm = w_lane_next;

  // Sign/zero extension of the assembled value.
  always_comb begin
    case (r_req.size)
      SZ_BYTE: w_ext = {{24{w_asm[7]  & ~r_req.uns}}, w_asm[7:0]};
      SZ_HALF: w_ext = {{16{w_asm[15] & ~r_req.uns}}, w_asm[15:0]};
      default: w_ext = w_asm;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_beat      <= 2'd0;
      r_req       <= '0;
      o_rsp_rdata <= 32'd0;
      o_rsp_err   <= 1'b0;
    end else if (i_clk_enable) begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_req.we    <= i_req_we;
            r_req.size  <= i_req_size;
            r_req.uns   <= i_req_unsigned;
            r_req.split <= w_misal;
            r_req.addr  <= i_req_addr;
            r_req.wdata <= i_req_wdata;
            r_beat      <= 2'd0;
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= w_req_err;
            // Errors skip the memory entirely and respond next cycle.
            r_state     <= w_req_err ? S_RESP : S_XFER;
          end
        end
        S_XFER: begin
          if (w_last) begin
            r_beat      <= 2'd0;
            o_rsp_rdata <= r_req.we ? 32'd0 : w_ext;
            r_state     <= S_RESP;
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
        S_RESP: begin
          o_rsp_rdata <= 32'd0;
          o_rsp_err   <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] mem_rd;

  logic        req_ready, busy, rsp_valid, rsp_err, mem_write, store_byte, store_half;
  logic [31:0] rsp_rdata, mem_addr, mem_data;
  logic        n_req_ready, n_busy, n_rsp_valid, n_rsp_err, n_mem_write, n_store_byte, n_store_half;
  logic [31:0] n_rsp_rdata, n_mem_addr, n_mem_data;

  always #5 clk = ~clk;

  lsu_mem_master #(.SPLIT_MISALIGNED(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_enable(clk_en),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_busy(busy), .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_mem_write(mem_write),
    .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_store_byte(store_byte),
    .o_store_half(store_half), .i_mem_data(mem_rd));

  // Reject-mode instance shares the request inputs; its memory port is only observed.
  lsu_mem_master #(.SPLIT_MISALIGNED(0)) dut_ns (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_enable(clk_en),
    .i_req_valid(req_valid), .o_req_ready(n_req_ready), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_busy(n_busy), .o_rsp_valid(n_rsp_valid),
    .o_rsp_rdata(n_rsp_rdata), .o_rsp_err(n_rsp_err), .o_mem_write(n_mem_write),
    .o_mem_addr(n_mem_addr), .o_mem_data(n_mem_data), .o_store_byte(n_store_byte),
    .o_store_half(n_store_half), .i_mem_data(mem_rd));

  // 4 KB byte memory model, address wraps within 12 bits.
  logic [7:0] mem [4096] = '{default: 8'h00};
  assign mem_rd = {mem[mem_addr[11:0] + 12'd3], mem[mem_addr[11:0] + 12'd2],
                   mem[mem_addr[11:0] + 12'd1], mem[mem_addr[11:0]]};

  typedef struct { logic [31:0] rdata; logic err; int lat; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic sb; logic sh; } wr_t;
  typedef struct {
    logic we; logic [1:0] size; logic uns; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] rdata; logic err; int lat; int nwr;
  } vec_t;

  exp_t exp_q[$];
  wr_t  wlog[$];
  int   total = 0;
  int   bad = 0;
  int   en_edges = 0;
  int   acc = 0;
  bit   seen = 1'b1;
  exp_t mon_e;
  wr_t  mon_w;
  logic [11:0] mon_wa;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on response, memory writes, enabled-edge latency.
  initial forever begin
    @(negedge clk);
    if (rsp_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected: got rdata %h want no response", rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        chk("rsp_latency", 32'(en_edges - acc + 1), 32'(mon_e.lat));
      end
    end
    if (clk_en && mem_write) begin
      mon_w.addr = mem_addr; mon_w.data = mem_data;
      mon_w.sb = store_byte; mon_w.sh = store_half;
      wlog.push_back(mon_w);
      mon_wa = mem_addr[11:0];
      mem[mon_wa] = mem_data[7:0];
      if (!store_byte) begin
        mem[mon_wa + 12'd1] = mem_data[15:8];
        if (!store_half) begin
          mem[mon_wa + 12'd2] = mem_data[23:16];
          mem[mon_wa + 12'd3] = mem_data[31:24];
        end
      end
    end
    if (clk_en) begin
      en_edges++;
      if (req_valid && req_ready) begin
        acc = en_edges;
        seen = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    total++;
    if (i >= 200) begin
      bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles want idle", i);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic err, input int lat);
    exp_t e;
    e.rdata = rd; e.err = err; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic check_beats(input vec_t v, input int n0);
    logic split; int nb; logic [31:0] m; wr_t w;
    split = (v.size == 2'b01 && v.addr[0]) || (v.size == 2'b10 && v.addr[1:0] != 2'b00);
    nb = split ? ((v.size == 2'b01) ? 2 : 4) : 1;
    for (int k = 0; k < nb; k++) begin
      if (n0 + k >= wlog.size()) break;
      w = wlog[n0 + k];
      chk("beat_addr", w.addr, v.addr + 32'(k));
      if (split) begin
        chk("beat_data", {24'd0, w.data[7:0]}, {24'd0, v.wdata[8*k +: 8]});
        chk("beat_mode", {30'd0, w.sb, w.sh}, 32'd2);
      end else begin
        m = (v.size == 2'b00) ? 32'hFF : (v.size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        chk("beat_data", w.data & m, v.wdata & m);
        chk("beat_mode", {30'd0, w.sb, w.sh}, {30'd0, v.size == 2'b00, v.size == 2'b01});
      end
    end
  endtask

  task automatic run_req(input vec_t v);
    int n0;
    push_exp(v.rdata, v.err, v.lat);
    n0 = wlog.size();
    drive(v.we, v.size, v.uns, v.addr, v.wdata);
    wait_idle();
    chk("write_count", 32'(wlog.size() - n0), 32'(v.nwr));
    if (v.we && !v.err) check_beats(v, n0);
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic err, input int lat, input int nwr);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
    v.rdata = rd; v.err = err; v.lat = lat; v.nwr = nwr;
    return v;
  endfunction

  // Reject-mode instance: misaligned request errors one cycle after accept, no writes.
  task automatic ns_case(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] split_rd);
    int nw;
    nw = 0;
    push_exp(split_rd, 1'b0, 3);
    drive(we, 2'b01, 1'b0, a, wd);
    @(negedge clk);
    if (n_mem_write) nw++;
    chk("ns_rsp_valid", 32'(n_rsp_valid), 32'd1);
    chk("ns_rsp_err", 32'(n_rsp_err), 32'd1);
    chk("ns_rsp_rdata", n_rsp_rdata, 32'd0);
    @(negedge clk);
    if (n_mem_write) nw++;
    chk("ns_rsp_once", 32'(n_rsp_valid), 32'd0);
    chk("ns_ready_again", {30'd0, n_req_ready, n_busy}, 32'd2);
    wait_idle();
    chk("ns_write_count", 32'(nw), 32'd0);
  endtask

  vec_t vt[24];
  int   n0;

  initial begin
    vt[0]  = mk(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1);
    vt[1]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);
    vt[2]  = mk(1'b1, 2'd0, 1'b0, 32'h0000_0200, 32'hAAAA_AA80, 32'h0, 1'b0, 2, 1);
    vt[3]  = mk(1'b1, 2'd0, 1'b0, 32'h0000_0201, 32'h5555_557F, 32'h0, 1'b0, 2, 1);
    vt[4]  = mk(1'b0, 2'd0, 1'b0, 32'h0000_0200, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0);
    vt[5]  = mk(1'b0, 2'd0, 1'b1, 32'h0000_0200, 32'h0, 32'h0000_0080, 1'b0, 2, 0);
    vt[6]  = mk(1'b0, 2'd1, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_7F80, 1'b0, 2, 0);
    vt[7]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_0300, 32'h1234_8001, 32'h0, 1'b0, 2, 1);
    vt[8]  = mk(1'b0, 2'd1, 1'b0, 32'h0000_0300, 32'h0, 32'hFFFF_8001, 1'b0, 2, 0);
    vt[9]  = mk(1'b0, 2'd1, 1'b1, 32'h0000_0300, 32'h0, 32'h0000_8001, 1'b0, 2, 0);
    vt[10] = mk(1'b1, 2'd2, 1'b0, 32'h0000_0103, 32'h1122_3344, 32'h0, 1'b0, 5, 4);
    vt[11] = mk(1'b0, 2'd2, 1'b0, 32'h0000_0103, 32'h0, 32'h1122_3344, 1'b0, 5, 0);
    vt[12] = mk(1'b0, 2'd1, 1'b0, 32'h0000_0105, 32'h0, 32'h0000_1122, 1'b0, 3, 0);
    vt[13] = mk(1'b0, 2'd1, 1'b1, 32'h0000_0101, 32'h0, 32'h0000_ADBE, 1'b0, 3, 0);
    vt[14] = mk(1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h0, 32'hFFFF_ADBE, 1'b0, 3, 0);
    vt[15] = mk(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'h44AD_BEEF, 1'b0, 2, 0);
    vt[16] = mk(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 1, 0);
    vt[17] = mk(1'b1, 2'd3, 1'b0, 32'h0000_0104, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0);
    vt[18] = mk(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hA5B6_C7D8, 32'h0, 1'b0, 5, 4);
    vt[19] = mk(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'hA5B6_C7D8, 1'b0, 5, 0);
    vt[20] = mk(1'b0, 2'd0, 1'b0, 32'h0000_0106, 32'h0, 32'h0000_0011, 1'b0, 2, 0);
    vt[21] = mk(1'b1, 2'd1, 1'b0, 32'h0000_0207, 32'h0000_CAFE, 32'h0, 1'b0, 3, 2);
    vt[22] = mk(1'b0, 2'd1, 1'b1, 32'h0000_0207, 32'h0, 32'h0000_CAFE, 1'b0, 3, 0);
    vt[23] = mk(1'b0, 2'd2, 1'b0, 32'h0000_0208, 32'h0, 32'h0000_00CA, 1'b0, 2, 0);

    // Reset state while reset is held.
    #2;
    chk("rst_ready_busy", {30'd0, req_ready, busy}, 32'd2);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_strobes", {29'd0, mem_write, store_byte, store_half}, 32'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(req_ready), 32'd1);

    foreach (vt[i]) run_req(vt[i]);

    // Enable held low for 3 cycles in the middle of a split store.
    push_exp(32'h0, 1'b0, 5);
    n0 = wlog.size();
    drive(1'b1, 2'd2, 1'b0, 32'h0000_0401, 32'hCAFE_F00D);
    @(posedge clk); #1;
    clk_en = 1'b0;
    chk("hold_pre_writes", 32'(wlog.size() - n0), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_addr", mem_addr, 32'h0000_0402);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_writes", 32'(wlog.size() - n0), 32'd1);
    end
    clk_en = 1'b1;
    wait_idle();
    chk("hold_total_writes", 32'(wlog.size() - n0), 32'd4);
    run_req(mk(1'b0, 2'd2, 1'b0, 32'h0000_0401, 32'h0, 32'hCAFE_F00D, 1'b0, 5, 0));

    // Reset during the third beat of a split store.
    n0 = wlog.size();
    drive(1'b1, 2'd2, 1'b0, 32'h0000_0501, 32'h5566_7788);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_beat_addr", mem_addr, 32'h0000_0503);
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", {29'd0, mem_write, store_byte, store_half}, 32'd0);
    chk("abort_state", {29'd0, busy, rsp_valid, rsp_err}, 32'd0);
    chk("abort_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {30'd0, req_ready, busy}, 32'd2);
    chk("abort_writes", 32'(wlog.size() - n0), 32'd2);
    chk("abort_mem", {mem[12'h504], mem[12'h503], mem[12'h502], mem[12'h501]}, 32'h0000_7788);
    run_req(mk(1'b0, 2'd2, 1'b0, 32'h0000_0501, 32'h0, 32'h0000_7788, 1'b0, 5, 0));

    // Reject mode: misaligned lh and sh.
    ns_case(1'b0, 32'h0000_0201, 32'h0, 32'h0000_007F);
    ns_case(1'b1, 32'h0000_0601, 32'h0000_BEEF, 32'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
